cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
Shares the two result-broadcast buses (common data buses, CDB) among NSRC functional-unit writeback sources, such as the ALU, multiplier and load/store reservation stations.
Sources cannot be stalled: each asserts writeback for one cycle and never retries.
The block therefore gives every source a small result FIFO and drains the FIFOs onto the buses in round-robin order.
Its bus outputs drive the writeback1/writeback2 inputs of every reservation station and of the reorder logic.

Parameters:
NSRC, 4, number of writeback sources (2..8)
DEPTH, 4, per-source FIFO depth in entries (power of 2, >=2)

Ports:
clk  input  1  clock, rising-edge
rst  input  1  asynchronous active-high reset
src_valid  input  NSRC  bit i: source i presents a result this cycle
src_vregid  input  5*NSRC  source i virtual reg id at [5i+4:5i]
src_dest  input  5*NSRC  source i architectural dest at [5i+4:5i]
src_val  input  32*NSRC  source i result at [32i+31:32i]
src_almost_full  output  NSRC  bit i: FIFO i count >= DEPTH-1 (combinational from count)
cdb1_en  output  1  bus 1 valid
cdb1_vregid  output  5  bus 1 virtual reg id
cdb1_dest  output  5  bus 1 dest
cdb1_val  output  32  bus 1 value
cdb2_en  output  1  bus 2 valid
cdb2_vregid  output  5  bus 2 virtual reg id
cdb2_dest  output  5  bus 2 dest
cdb2_val  output  32  bus 2 value
overflow  output  1  sticky: a result was dropped

Behaviour:
- Reset (asynchronous, any time including mid-drain):
  - All FIFOs empty; round-robin pointer rr = 0.
  - cdb1_en and cdb2_en = 0; all bus fields = 0; overflow = 0.
  - Results in flight are discarded.
- Per-source FIFO i:
  - Each entry is {vregid, dest, val} (42 bits).
  - Head/tail pointers wrap modulo DEPTH; count is 0..DEPTH.
  - Enqueue on the edge where src_valid[i] = 1.
- Selection, combinational, each cycle, from the registered FIFO state:
  - g1 = first non-empty FIFO scanning rr, rr+1, ... (mod NSRC).
  - g2 = next non-empty FIFO scanning g1+1 onward, stopping before rr is reached again.
  - A FIFO never grants twice in one cycle.
- Bus registers, updated at the edge:
  - cdb1_* <= head of g1, or cdb1_en <= 0 if no g1.
  - cdb2_* <= head of g2, or cdb2_en <= 0 if no g2.
  - Granted FIFOs pop.
  - When the en signal is 0, the data fields hold their previous value (don't-care).
- rr update:
  - rr <= (last granted index + 1) mod NSRC.
  - Last granted index is g2 if it exists, else g1.
  - rr is unchanged when nothing is granted.
- Latency: src_valid high in cycle t with FIFO empty gives cdb*_en high in cycle t+2. No bypass path.
- Ordering: results from the same source leave in arrival order. No ordering is guaranteed across sources.
- Simultaneous enqueue and pop on the same FIFO: both take effect and count is unchanged. This is legal even when count = DEPTH.
- Enqueue while count = DEPTH and no pop:
  - The entry is dropped and FIFO contents are unchanged.
  - overflow <= 1 and stays 1 until reset.
- src_almost_full gives upstream an issue-throttle hint. The arbiter itself never blocks.
- With 2 or fewer sources non-empty, every head drains in the same cycle.
- Sustained throughput: 2 results per cycle.

Test Plan:
- Reset, then src_valid = 0001 for one cycle (vregid 5, dest 3, val 0x1234) → cycle t+2: cdb1_en = 1 with {5, 3, 0x1234}, cdb2_en = 0; rr becomes 1.
- From rr = 0, src_valid = 1111 for one cycle with values 0xA0..0xA3 →
  - first drain cycle: bus1 = src0, bus2 = src1;
  - next cycle: bus1 = src2, bus2 = src3;
  - following cycle: both en = 0; rr ends at 0.
- Source 2 pulses every cycle for 6 cycles (vals 1..6), others idle → values appear in order 1..6 on cdb1 only, one per cycle. count never exceeds 1 and src_almost_full[2] stays 0.
- All 4 sources pulse every cycle for 8 cycles → almost_full rises once count reaches 3, then overflow = 1. Drained values per source are in order, with the dropped entries missing.
- FIFO 0 full (count 4) with source 0 granted, plus a new src_valid[0] in the same cycle → entry accepted, count stays 4, overflow stays 0.
- Assert rst asynchronously mid-drain with FIFOs non-empty → cdb1_en, cdb2_en and overflow go 0 immediately. After release, buses stay idle until new src_valid, and the first grant starts at rr = 0.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// Writeback-source and result-bus signals of the CDB arbiter.
// The master side is the set of functional units plus the bus consumers.
// The slave side is the arbiter itself.
interface cdb_arbiter_if #(
   parameter int NSRC = 4
);
   logic [NSRC-1:0]    src_valid;
   logic [5*NSRC-1:0]  src_vregid;
   logic [5*NSRC-1:0]  src_dest;
   logic [32*NSRC-1:0] src_val;
   logic [NSRC-1:0]    src_almost_full;
   logic               cdb1_en;
   logic [4:0]         cdb1_vregid;
   logic [4:0]         cdb1_dest;
   logic [31:0]        cdb1_val;
   logic               cdb2_en;
   logic [4:0]         cdb2_vregid;
   logic [4:0]         cdb2_dest;
   logic [31:0]        cdb2_val;
   logic               overflow;

   modport master (
      output src_valid, src_vregid, src_dest, src_val,
      input  src_almost_full,
      input  cdb1_en, cdb1_vregid, cdb1_dest, cdb1_val,
      input  cdb2_en, cdb2_vregid, cdb2_dest, cdb2_val,
      input  overflow
   );

   modport slave (
      input  src_valid, src_vregid, src_dest, src_val,
      output src_almost_full,
      output cdb1_en, cdb1_vregid, cdb1_dest, cdb1_val,
      output cdb2_en, cdb2_vregid, cdb2_dest, cdb2_val,
      output overflow
   );
endinterface

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one small FIFO per writeback source, drained round-robin onto
// two registered result buses (up to two results per cycle, never stalls a source).
module cdb_arbiter #(
   parameter int NSRC  = 4,
   parameter int DEPTH = 4
) (
   input  logic           clk,
   input  logic           rst,
   cdb_arbiter_if.slave   bus
);
   localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1;
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef logic [IW-1:0] idx_t;
   typedef logic [PW-1:0] ptr_t;
   typedef logic [PW:0]   cnt_t;

   typedef struct packed {
      logic [4:0]  vregid;
      logic [4:0]  dest;
      logic [31:0] val;
   } entry_t;

   // FIFO storage and bookkeeping
   entry_t mem_q   [NSRC][DEPTH];
   ptr_t   head_q  [NSRC];
   ptr_t   tail_q  [NSRC];
   cnt_t   count_q [NSRC];
   idx_t   rr_q;

   // Registered bus outputs
   logic   cdb1_en_q;
   entry_t cdb1_q;
   logic   cdb2_en_q;
   entry_t cdb2_q;
   logic   overflow_q;

   // Combinational selection results
   logic [NSRC-1:0] nonempty;
   logic [NSRC-1:0] almost_full;
   logic [NSRC-1:0] pop;
   logic [NSRC-1:0] accept;
   logic            drop_any;
   logic            g1_v;
   logic            g2_v;
   idx_t            g1;
   idx_t            g2;
   idx_t            rr_d;

   function automatic idx_t wrap_inc(input idx_t x);
      return (x == idx_t'(NSRC - 1)) ? '0 : x + 1'b1;
   endfunction

   // Per-FIFO status flags derived from the registered counts
   always_comb begin
      for (int i = 0; i < NSRC; i++) begin
         nonempty[i]    = (count_q[i] != '0);
         almost_full[i] = (count_q[i] >= cnt_t'(DEPTH - 1));
      end
   end

   // Round-robin scan: first two non-empty FIFOs starting at rr, no wrap past rr
   always_comb begin
      logic [IW:0] sum;
      idx_t        sel;
      // NOTE: combinational blocks use blocking '=' and assign every output a
      // default first, so the scan reads its own partial results and no latch is inferred.
      g1_v = 1'b0;
      g2_v = 1'b0;
      g1   = '0;
      g2   = '0;
      sum  = '0;
      sel  = '0;
      for (int k = 0; k < NSRC; k++) begin
         sum = {1'b0, rr_q} + (IW+1)'(k);
         if (sum >= (IW+1)'(NSRC)) sum = sum - (IW+1)'(NSRC);
         sel = sum[IW-1:0];
         if (nonempty[sel]) begin
            if (!g1_v) begin
               g1_v = 1'b1;
               g1   = sel;
            end else if (!g2_v) begin
               g2_v = 1'b1;
               g2   = sel;
            end
         end
      end
   end

   // Pop / accept / drop decisions and the next round-robin pointer
   always_comb begin
      drop_any = 1'b0;
      for (int i = 0; i < NSRC; i++) begin
         pop[i]    = (g1_v && (g1 == idx_t'(i))) || (g2_v && (g2 == idx_t'(i)));
         // A full FIFO still accepts when its head leaves in the same cycle
         accept[i] = bus.src_valid[i] && ((count_q[i] != cnt_t'(DEPTH)) || pop[i]);
         if (bus.src_valid[i] && !accept[i]) drop_any = 1'b1;
      end
      if (g2_v)      rr_d = wrap_inc(g2);
      else if (g1_v) rr_d = wrap_inc(g1);
      else           rr_d = rr_q;
   end

   // FIFO payload write
   // NOTE: the storage array has no reset; validity is tracked solely by the
   // reset pointers and counts, so stale contents are never observed.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NSRC; i++) begin
         if (accept[i]) begin
            mem_q[i][tail_q[i]] <= '{vregid: bus.src_vregid[5*i +: 5],
                                     dest:   bus.src_dest[5*i +: 5],
                                     val:    bus.src_val[32*i +: 32]};
         end
      end
   end

   // Pointers, counts, round-robin state, bus registers and sticky overflow
   // NOTE: sequential state uses non-blocking '<=' so every register samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NSRC; i++) begin
            head_q[i]  <= '0;
            tail_q[i]  <= '0;
            count_q[i] <= '0;
         end
         rr_q       <= '0;
         cdb1_en_q  <= 1'b0;
         cdb1_q     <= '0;
         cdb2_en_q  <= 1'b0;
         cdb2_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         for (int i = 0; i < NSRC; i++) begin
            if (pop[i])    head_q[i] <= head_q[i] + ptr_t'(1);
            if (accept[i]) tail_q[i] <= tail_q[i] + ptr_t'(1);
            count_q[i] <= count_q[i] + cnt_t'(accept[i]) - cnt_t'(pop[i]);
         end
         rr_q <= rr_d;
         cdb1_en_q <= g1_v;
         if (g1_v) cdb1_q <= mem_q[g1][head_q[g1]];
         cdb2_en_q <= g2_v;
         if (g2_v) cdb2_q <= mem_q[g2][head_q[g2]];
         if (drop_any) overflow_q <= 1'b1;
      end
   end

   assign bus.src_almost_full = almost_full;
   assign bus.cdb1_en         = cdb1_en_q;
   assign bus.cdb1_vregid     = cdb1_q.vregid;
   assign bus.cdb1_dest       = cdb1_q.dest;
   assign bus.cdb1_val        = cdb1_q.val;
   assign bus.cdb2_en         = cdb2_en_q;
   assign bus.cdb2_vregid     = cdb2_q.vregid;
   assign bus.cdb2_dest       = cdb2_q.dest;
   assign bus.cdb2_val        = cdb2_q.val;
   assign bus.overflow        = overflow_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: queue-based reference model of the
// per-source FIFOs and two-bus round-robin drain, plus literal spot checks.
module tb_cdb_arbiter;
   localparam int NSRC  = 4;
   localparam int DEPTH = 4;

   typedef logic [41:0] ent_t;   // {vregid, dest, val}

   logic clk = 1'b0;
   logic rst;

   cdb_arbiter_if #(.NSRC(NSRC)) bus ();

   cdb_arbiter #(.NSRC(NSRC), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference model state
   ent_t mq [NSRC][$];
   int   m_rr;
   logic m_en1, m_en2, m_ovf;
   ent_t m_b1, m_b2;

   // Stimulus for the current cycle
   logic [NSRC-1:0] in_v;
   ent_t            in_e [NSRC];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic ent_t bus1();
      return {bus.cdb1_vregid, bus.cdb1_dest, bus.cdb1_val};
   endfunction

   function automatic ent_t bus2();
      return {bus.cdb2_vregid, bus.cdb2_dest, bus.cdb2_val};
   endfunction

   function automatic ent_t mk(input int vreg, input int dst, input logic [31:0] v);
      return {5'(vreg), 5'(dst), v};
   endfunction

   task automatic apply_inputs();
      bus.src_valid = in_v;
      for (int i = 0; i < NSRC; i++) begin
         bus.src_vregid[5*i +: 5] = in_e[i][41:37];
         bus.src_dest[5*i +: 5]   = in_e[i][36:32];
         bus.src_val[32*i +: 32]  = in_e[i][31:0];
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NSRC; i++) mq[i].delete();
      m_rr  = 0;
      m_en1 = 1'b0;
      m_en2 = 1'b0;
      m_b1  = '0;
      m_b2  = '0;
      m_ovf = 1'b0;
   endtask

   // One clock of the reference: take the first two non-empty queues in
   // rotated order from rr, send their heads, then enqueue arrivals.
   task automatic model_step();
      int g[$];
      for (int k = 0; k < NSRC; k++) begin
         int idx = (m_rr + k) % NSRC;
         if (mq[idx].size() > 0 && g.size() < 2) g.push_back(idx);
      end
      m_en1 = (g.size() > 0);
      m_en2 = (g.size() > 1);
      if (m_en1) m_b1 = mq[g[0]][0];
      if (m_en2) m_b2 = mq[g[1]][0];
      foreach (g[j]) void'(mq[g[j]].pop_front());
      for (int i = 0; i < NSRC; i++) begin
         if (in_v[i]) begin
            if (mq[i].size() < DEPTH) mq[i].push_back(in_e[i]);
            else m_ovf = 1'b1;
         end
      end
      if (g.size() > 0) m_rr = (g[g.size()-1] + 1) % NSRC;
   endtask

   // Compare every DUT output against the model
   task automatic compare_all();
      logic [NSRC-1:0] exp_af;
      for (int i = 0; i < NSRC; i++) exp_af[i] = (mq[i].size() >= DEPTH - 1);
      check("cdb1_en", bus.cdb1_en, m_en1);
      check("cdb2_en", bus.cdb2_en, m_en2);
      if (m_en1) check("cdb1_data", bus1(), m_b1);
      if (m_en2) check("cdb2_data", bus2(), m_b2);
      check("overflow", bus.overflow, m_ovf);
      check("almost_full", bus.src_almost_full, exp_af);
   endtask

   // Inputs applied at edge+1, model advanced, outputs compared at next edge+1
   task automatic step();
      apply_inputs();
      model_step();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic idle(input int n);
      in_v = '0;
      for (int c = 0; c < n; c++) step();
   endtask

   task automatic randomize_entries();
      for (int i = 0; i < NSRC; i++) in_e[i] = ent_t'({$urandom(), $urandom()});
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge
   task automatic async_reset();
      in_v = '0;
      apply_inputs();
      #3;
      rst = 1'b1;
      model_reset();
      #1;
      check("rst_cdb1_en", bus.cdb1_en, 1'b0);
      check("rst_cdb2_en", bus.cdb2_en, 1'b0);
      check("rst_overflow", bus.overflow, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      logic [31:0] got [$];
      rst  = 1'b1;
      in_v = '0;
      for (int i = 0; i < NSRC; i++) in_e[i] = '0;
      apply_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset_bus1", {bus.cdb1_en, bus1()}, '0);
      check("reset_bus2", {bus.cdb2_en, bus2()}, '0);
      check("reset_af", bus.src_almost_full, '0);
      rst = 1'b0;

      // Single result: visible two cycles after src_valid
      in_v = 4'b0001;
      in_e[0] = mk(5, 3, 32'h1234);
      step();
      check("lat_t1_en", bus.cdb1_en, 1'b0);
      idle(1);
      check("lat_t2_en1", bus.cdb1_en, 1'b1);
      check("lat_t2_data", bus1(), mk(5, 3, 32'h1234));
      check("lat_t2_en2", bus.cdb2_en, 1'b0);
      // rr is now 1: sources 0 and 2 pending -> bus1 gets src2, bus2 gets src0
      in_v = 4'b0101;
      in_e[0] = mk(1, 1, 32'hB0);
      in_e[2] = mk(2, 2, 32'hB2);
      step();
      idle(1);
      check("rr1_bus1", bus.cdb1_val, 32'hB2);
      check("rr1_bus2", bus.cdb2_val, 32'hB0);

      // All four sources at once from rr = 0
      async_reset();
      in_v = 4'b1111;
      for (int i = 0; i < NSRC; i++) in_e[i] = mk(i, i, 32'hA0 + i);
      step();
      idle(1);
      check("all4_c1_b1", bus.cdb1_val, 32'hA0);
      check("all4_c1_b2", bus.cdb2_val, 32'hA1);
      idle(1);
      check("all4_c2_b1", bus.cdb1_val, 32'hA2);
      check("all4_c2_b2", bus.cdb2_val, 32'hA3);
      idle(1);
      check("all4_c3_en", {bus.cdb1_en, bus.cdb2_en}, 2'b00);

      // Source 2 streaming: one per cycle on bus1, FIFO never fills
      for (int c = 0; c < 9; c++) begin
         in_v = (c < 6) ? 4'b0100 : 4'b0000;
         in_e[2] = mk(c, c, 32'(c + 1));
         step();
         check("stream_af2", bus.src_almost_full[2], 1'b0);
         if (bus.cdb1_en) got.push_back(bus.cdb1_val);
      end
      check("stream_count", got.size(), 6);
      for (int j = 0; j < got.size(); j++) check("stream_order", got[j], 32'(j + 1));

      // All sources every cycle: FIFOs fill, full+pop accepts, then overflow
      async_reset();
      for (int c = 1; c <= 8; c++) begin
         in_v = 4'b1111;
         randomize_entries();
         step();
         if (c == 4) check("burst_af_c4", bus.src_almost_full, 4'b1100);
         if (c == 7) check("burst_ovf_c7", bus.overflow, 1'b0);
         if (c == 8) check("burst_ovf_c8", bus.overflow, 1'b1);
      end
      idle(10);

      // Reset in the middle of a drain, then fresh traffic restarts at rr = 0
      for (int c = 0; c < 8; c++) begin
         in_v = 4'b1111;
         randomize_entries();
         step();
      end
      idle(1);
      async_reset();
      idle(3);
      check("post_rst_idle", {bus.cdb1_en, bus.cdb2_en}, 2'b00);
      in_v = 4'b0101;
      in_e[0] = mk(7, 7, 32'hC0);
      in_e[2] = mk(9, 9, 32'hC2);
      step();
      idle(1);
      check("post_rst_b1", bus.cdb1_val, 32'hC0);
      check("post_rst_b2", bus.cdb2_val, 32'hC2);

      // Randomized traffic with occasional asynchronous reset
      for (int c = 0; c < 500; c++) begin
         int load = (c / 100) % 3;
         for (int i = 0; i < NSRC; i++)
            in_v[i] = ($urandom_range(0, 3) < 1 + load);
         randomize_entries();
         step();
         if ($urandom_range(0, 149) == 0) async_reset();
      end
      idle(10);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
